// File: rtl/nand_flash_controller_pkg.sv
// Shared types and constants for the NAND command-script sequencer.
// Holds the sequencer state encoding, default timing values and the common NAND opcodes.
// Contents: state_t, *_DEF timing/size defaults, TMR_W, OP_* opcode bytes.
package nand_flash_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SETUP,
        HOLD,
        DONE
    } state_t;

    localparam int CMD_SIZE_DEF = 7;
    localparam int ADDR_W_DEF   = 12;
    localparam int WE_LOW_DEF   = 2;
    localparam int WE_HIGH_DEF  = 2;

    // Width of the we low/high phase timer; phases up to 256 clocks.
    localparam int TMR_W = 8;

    localparam logic [7:0] OP_READ_1  = 8'h00;
    localparam logic [7:0] OP_READ_2  = 8'h30;
    localparam logic [7:0] OP_PROG_1  = 8'h80;
    localparam logic [7:0] OP_PROG_2  = 8'h10;
    localparam logic [7:0] OP_ERASE_1 = 8'h60;
    localparam logic [7:0] OP_ERASE_2 = 8'hD0;
    localparam logic [7:0] OP_READ_ID = 8'h90;
    localparam logic [7:0] OP_RESET   = 8'hFF;

endpackage

// File: rtl/nand_latch_cycle.sv
// One NAND write-direction latch cycle: we low for WE_LOW clocks, then high for WE_HIGH clocks.
// Latency: start captures data/flags at the edge; done is asserted on the last high clock.
// Ports: clk, rst, start/data/cle_flag/ale_flag in; we, cle, ale, io_drive_en, io_data, low_done, done out.
module nand_latch_cycle
    import nand_flash_controller_pkg::*;
#(
    parameter int WE_LOW  = WE_LOW_DEF,
    parameter int WE_HIGH = WE_HIGH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       cle_flag,
    input  logic       ale_flag,
    output logic       we,
    output logic       cle,
    output logic       ale,
    output logic       io_drive_en,
    output logic [7:0] io_data,
    output logic       low_done,
    output logic       done
);

    logic [TMR_W-1:0] tmr;

    // io_drive_en marks an active cycle; we itself tells which phase we are in.
    assign low_done = io_drive_en && !we && (tmr == '0);
    assign done     = io_drive_en &&  we && (tmr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we          <= 1'b1;
            cle         <= 1'b0;
            ale         <= 1'b0;
            io_drive_en <= 1'b0;
            io_data     <= 8'h00;
            tmr         <= '0;
        end else if (start) begin
            we          <= 1'b0;
            io_drive_en <= 1'b1;
            cle         <= cle_flag;
            ale         <= ale_flag;
            io_data     <= data;
            tmr         <= TMR_W'(WE_LOW - 1);
        end else if (low_done) begin
            // Rising we edge; io/cle/ale stay put to provide hold time.
            we  <= 1'b1;
            tmr <= TMR_W'(WE_HIGH - 1);
        end else if (done) begin
            io_drive_en <= 1'b0;
            cle         <= 1'b0;
            ale         <= 1'b0;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

endmodule

// File: rtl/nand_flash_controller.sv
// Reads a CMD_SIZE-byte script from command RAM and issues it as NAND cle/ale latch cycles.
// Latency: FETCH one clock after ready is seen in IDLE; 2+WE_LOW+WE_HIGH clocks per byte.
// Ports: clk, rst, cmd_rambus, ready in; ram_addr, ram_r_e, cle, ce, re, ale, we, io_drive_en out; io inout.
module nand_flash_controller
    import nand_flash_controller_pkg::*;
#(
    parameter int CMD_SIZE = CMD_SIZE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WE_LOW   = WE_LOW_DEF,
    parameter int WE_HIGH  = WE_HIGH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        cmd_rambus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_r_e,
    output logic              cle,
    output logic              ce,
    output logic              re,
    output logic              ale,
    output logic              we,
    inout  wire  [7:0]        io,
    input  logic              ready,
    output logic              io_drive_en
);

    localparam int IDX_W = $clog2(CMD_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_SIZE - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             start;
    logic             low_done;
    logic             done;
    logic             cle_flag;
    logic [7:0]       io_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        ram_r_e   = 1'b0;
        ce        = 1'b1;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (ready) begin
                    state_nxt = FETCH;
                    idx_nxt   = '0;
                end
            end
            FETCH: begin
                ram_r_e   = 1'b1;
                ce        = 1'b0;
                state_nxt = LOAD;
            end
            LOAD: begin
                // RAM data requested in FETCH is valid now; latch block captures it.
                ram_r_e   = 1'b1;
                ce        = 1'b0;
                start     = 1'b1;
                state_nxt = SETUP;
            end
            SETUP: begin
                ce = 1'b0;
                if (low_done) state_nxt = HOLD;
            end
            HOLD: begin
                ce = 1'b0;
                if (done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            DONE: begin
                // Wait for ready to drop so a held-high ready cannot retrigger.
                if (!ready) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // First and last script bytes are commands, everything between is address.
    assign cle_flag = (idx == '0) || (idx == LAST_IDX);

    nand_latch_cycle #(
        .WE_LOW  (WE_LOW),
        .WE_HIGH (WE_HIGH)
    ) u_latch (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data        (cmd_rambus),
        .cle_flag    (cle_flag),
        .ale_flag    (!cle_flag),
        .we          (we),
        .cle         (cle),
        .ale         (ale),
        .io_drive_en (io_drive_en),
        .io_data     (io_data),
        .low_done    (low_done),
        .done        (done)
    );

    assign ram_addr = ADDR_W'(idx);
    assign re       = 1'b1;
    assign io       = io_drive_en ? io_data : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_nand_flash_controller.sv
// Scoreboard bench for nand_flash_controller with a RAM model and randomized scripts.
// Expected bytes/addresses are queued at stimulus time; a negedge monitor pops and compares.
// Ports: none (top-level bench).
module tb_nand_flash_controller;

    localparam int CMD_SIZE = 7;
    localparam int ADDR_W   = 12;
    localparam int WE_LOW   = 2;
    localparam int WE_HIGH  = 2;
    localparam int RUN_CLKS = CMD_SIZE * (2 + WE_LOW + WE_HIGH);

    logic              clk    = 1'b0;
    logic              clk_en = 1'b0;
    logic              rst    = 1'b0;
    logic              ready  = 1'b0;
    logic [7:0]        cmd_rambus = 8'h00;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_r_e, cle, ce, re, ale, we, io_drive_en;
    wire  [7:0]        io;

    logic [7:0] mem [0:15];

    typedef struct {
        logic [7:0] dat;
        logic       cle;
        logic       ale;
    } exp_t;

    exp_t exp_q[$];
    int   addr_q[$];

    int total = 0;
    int bad   = 0;

    nand_flash_controller #(
        .CMD_SIZE (CMD_SIZE),
        .ADDR_W   (ADDR_W),
        .WE_LOW   (WE_LOW),
        .WE_HIGH  (WE_HIGH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rambus  (cmd_rambus),
        .ram_addr    (ram_addr),
        .ram_r_e     (ram_r_e),
        .cle         (cle),
        .ce          (ce),
        .re          (re),
        .ale         (ale),
        .we          (we),
        .io          (io),
        .ready       (ready),
        .io_drive_en (io_drive_en)
    );

    always #5 if (clk_en) clk = ~clk;

    // Registered-read command RAM, one clock latency.
    always @(posedge clk) if (ram_r_e) cmd_rambus <= mem[ram_addr[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference model: byte i goes out as a command if first/last, address otherwise.
    task automatic load_script(input bit rnd);
        exp_t e;
        logic [7:0] fixed [0:6];
        fixed = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h30};
        for (int i = 0; i < CMD_SIZE; i++) begin
            mem[i] = rnd ? 8'($urandom_range(0, 255)) : fixed[i];
            e.dat  = mem[i];
            e.cle  = (i == 0) || (i == CMD_SIZE - 1);
            e.ale  = !e.cle;
            exp_q.push_back(e);
            addr_q.push_back(i);
        end
    endtask

    // Monitor state
    logic p_we = 1'b1, p_rre = 1'b0, p_drv = 1'b0, p_ce = 1'b1;
    int   low_n = 0, hold_n = 0, ce_n = 0, runs = 0, rises = 0;
    bit   overlap = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            p_we = 1'b1; p_rre = 1'b0; p_drv = 1'b0; p_ce = 1'b1;
            low_n = 0; hold_n = 0; ce_n = 0; overlap = 1'b0;
        end else begin
            if (we && !p_we) begin
                rises++;
                check("we_low_width", low_n, WE_LOW);
                if (exp_q.size() == 0) begin
                    check("unexpected_we_edge", rises, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("io_at_we_rise", {24'h0, io}, {24'h0, e.dat});
                    check("cle_ale_at_we_rise", {30'h0, cle, ale}, {30'h0, e.cle, e.ale});
                end
                low_n  = 0;
                hold_n = 0;
            end
            if (!io_drive_en && p_drv) check("we_high_hold", hold_n, WE_HIGH);
            if (ram_r_e && !p_rre) begin
                if (addr_q.size() == 0) check("unexpected_fetch", ram_addr, 32'hFFFF_FFFF);
                else                    check("ram_addr", ram_addr, addr_q.pop_front());
            end
            if (ce && !p_ce) begin
                runs++;
                check("ce_low_clocks", ce_n, RUN_CLKS);
                check("rre_drv_overlap", {31'h0, overlap}, 32'h0);
                check("re_high", {31'h0, re}, 32'h1);
                ce_n    = 0;
                overlap = 1'b0;
            end
            if (ram_r_e && io_drive_en) overlap = 1'b1;
            if (!we) low_n++;
            if (we && io_drive_en) hold_n++;
            if (!ce) ce_n++;
            p_we = we; p_rre = ram_r_e; p_drv = io_drive_en; p_ce = ce;
        end
    end

    task automatic wait_runs(input int target);
        for (int c = 0; c < 20 * RUN_CLKS && runs < target; c++) @(negedge clk);
        check("run_complete", {31'h0, runs >= target}, 32'h1);
        check("queue_drained", exp_q.size() + addr_q.size(), 0);
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ce"},      {31'h0, ce},          32'h1);
        check({tag, "_we"},      {31'h0, we},          32'h1);
        check({tag, "_re"},      {31'h0, re},          32'h1);
        check({tag, "_cle_ale"}, {30'h0, cle, ale},    32'h0);
        check({tag, "_ram_r_e"}, {31'h0, ram_r_e},     32'h0);
        check({tag, "_drv"},     {31'h0, io_drive_en}, 32'h0);
        check({tag, "_io_z"},    {24'h0, io},          {24'h0, 8'hzz});
    endtask

    initial begin
        int n;
        int r0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset with no clock running.
        #1 rst = 1'b1;
        #1 check_idle_pins("reset");
        check("reset_addr", ram_addr, 0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fixed example script.
        load_script(1'b0);
        ready = 1'b1;
        wait_runs(1);

        // ready held high after DONE: nothing new.
        n = rises;
        repeat (3 * RUN_CLKS) @(negedge clk);
        check("no_restart_edges", rises, n);
        check("no_restart_runs", runs, 1);
        check_idle_pins("done");

        // Low then high restarts with a fresh script.
        ready = 1'b0;
        repeat (2) @(negedge clk);
        load_script(1'b1);
        ready = 1'b1;
        wait_runs(2);

        // ready dropped during the third byte.
        ready = 1'b0;
        repeat (2) @(negedge clk);
        load_script(1'b1);
        ready = 1'b1;
        repeat (2 * (2 + WE_LOW + WE_HIGH) + 3) @(negedge clk);
        ready = 1'b0;
        wait_runs(3);

        // Randomized runs with ready released at a random point.
        for (int r = 0; r < 4; r++) begin
            ready = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            load_script(1'b1);
            ready = 1'b1;
            repeat ($urandom_range(1, RUN_CLKS - 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) ready = 1'b0;
            wait_runs(4 + r);
        end

        // Reset in the middle of an address SETUP.
        ready = 1'b0;
        repeat (2) @(negedge clk);
        load_script(1'b1);
        ready = 1'b1;
        r0 = 0;
        for (int c = 0; c < 4 * RUN_CLKS; c++) begin
            @(posedge clk);
            #1;
            if (!we && ale) begin
                r0 = 1;
                break;
            end
        end
        check("reached_addr_setup", r0, 1);
        #2 rst = 1'b1;
        #1 check_idle_pins("midreset");
        ready = 1'b0;
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = runs;
        repeat (2) @(negedge clk);
        load_script(1'b1);
        ready = 1'b1;
        wait_runs(n + 1);
        ready = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
